// File: rtl/truthtable_sweeper.sv
// Drives rows 0..7 into a 3-input truth-table circuit, captures f, and compares against EXPECTED.
// Optional first-failure capture is enabled by defining TT_FIRST_FAIL_EN.
//
// state  | meaning
// IDLE   | rows parked at 000, waiting for start
// SWEEP  | driving rows, settle timer counts down, f sampled at terminal count
// FINISH | one-cycle done pulse, match valid, rows back at 000
module truthtable_sweeper #(
   parameter int          SETTLE_CYCLES = 1,
   parameter logic [7:0]  EXPECTED      = 8'hAC
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   output logic       x3,
   output logic       x2,
   output logic       x1,
   input  logic       f,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
`ifdef TT_FIRST_FAIL_EN
   output logic [2:0] first_fail_row,
   output logic       first_fail_valid,
`endif
   output logic       match
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_t     state, state_nxt;
   logic [2:0] row, row_nxt;
   logic [3:0] settle, settle_nxt;
   logic       busy_nxt, done_nxt, match_nxt;
   logic [7:0] table_nxt;
`ifdef TT_FIRST_FAIL_EN
   logic [2:0] ff_row_nxt;
   logic       ff_valid_nxt;
`endif

   assign {x3, x2, x1} = row;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         row       <= 3'd0;
         settle    <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_out <= 8'h00;
         match     <= 1'b0;
`ifdef TT_FIRST_FAIL_EN
         first_fail_row   <= 3'd0;
         first_fail_valid <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         row       <= row_nxt;
         settle    <= settle_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         table_out <= table_nxt;
         match     <= match_nxt;
`ifdef TT_FIRST_FAIL_EN
         first_fail_row   <= ff_row_nxt;
         first_fail_valid <= ff_valid_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      row_nxt    = row;
      settle_nxt = settle;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      table_nxt  = table_out;
      match_nxt  = match;
`ifdef TT_FIRST_FAIL_EN
      ff_row_nxt   = first_fail_row;
      ff_valid_nxt = first_fail_valid;
`endif

      case (state)
         IDLE: begin
            row_nxt = 3'd0;
            if (start) begin
               state_nxt  = SWEEP;
               busy_nxt   = 1'b1;
               settle_nxt = SETTLE_LOAD;
               table_nxt  = 8'h00;
               match_nxt  = 1'b0;
`ifdef TT_FIRST_FAIL_EN
               ff_row_nxt   = 3'd0;
               ff_valid_nxt = 1'b0;
`endif
            end
         end

         SWEEP: begin
            if (settle != 4'd0) begin
               settle_nxt = settle - 4'd1;
            end else begin
               // Terminal count: this is the last cycle the row is held.
               table_nxt[row] = f;
               settle_nxt     = SETTLE_LOAD;
`ifdef TT_FIRST_FAIL_EN
               if (!first_fail_valid && (f != EXPECTED[row])) begin
                  ff_row_nxt   = row;
                  ff_valid_nxt = 1'b1;
               end
`endif
               if (row == 3'd7) begin
                  state_nxt = FINISH;
                  row_nxt   = 3'd0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  match_nxt = (table_nxt == EXPECTED);
               end else begin
                  row_nxt = row + 3'd1;
               end
            end
         end

         FINISH: begin
            state_nxt = IDLE;
            row_nxt   = 3'd0;
         end

         default: begin
            state_nxt = IDLE;
            row_nxt   = 3'd0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_truthtable_sweeper.sv
// Directed bench for truthtable_sweeper: default-settle instance on a selectable f,
// plus a zero-settle instance with f = x1.
module tb_truthtable_sweeper;

   logic       clk;
   logic       resetn;
   logic       start0, start1;
   logic       x3_0, x2_0, x1_0, f0, busy0, done0, match0;
   logic [7:0] table0;
   logic       x3_1, x2_1, x1_1, f1, busy1, done1, match1;
   logic [7:0] table1;
   logic       fstuck;
`ifdef TT_FIRST_FAIL_EN
   logic [2:0] ffrow0, ffrow1;
   logic       ffval0, ffval1;
`endif

   int checks = 0;
   int errors = 0;

   assign f0 = fstuck ? 1'b0 : ((~x3_0 & x2_0) | (x3_0 & x1_0));
   assign f1 = x1_1;

   truthtable_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hAC)) dut0 (
      .clk(clk), .resetn(resetn), .start(start0),
      .x3(x3_0), .x2(x2_0), .x1(x1_0), .f(f0),
      .busy(busy0), .done(done0), .table_out(table0),
`ifdef TT_FIRST_FAIL_EN
      .first_fail_row(ffrow0), .first_fail_valid(ffval0),
`endif
      .match(match0)
   );

   truthtable_sweeper #(.SETTLE_CYCLES(0), .EXPECTED(8'hAC)) dut1 (
      .clk(clk), .resetn(resetn), .start(start1),
      .x3(x3_1), .x2(x2_1), .x1(x1_1), .f(f1),
      .busy(busy1), .done(done1), .table_out(table1),
`ifdef TT_FIRST_FAIL_EN
      .first_fail_row(ffrow1), .first_fail_valid(ffval1),
`endif
      .match(match1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench sampling in cycle T+1, where T is the accepting edge.
   task automatic pulse0();
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   int done_cnt;
   int done_at[$];

   initial begin
      resetn = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      fstuck = 1'b0;
      @(negedge clk);
      chk("rst_rows",  {29'd0, x3_0, x2_0, x1_0}, 32'd0);
      chk("rst_busy",  busy0, 0);
      chk("rst_done",  done0, 0);
      chk("rst_table", table0, 0);
      chk("rst_match", match0, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Test 1: correct function, rows held two cycles each
      pulse0();
      for (int k = 1; k <= 16; k++) begin
         chk("t1_row",  {29'd0, x3_0, x2_0, x1_0}, 32'((k - 1) / 2));
         chk("t1_busy", busy0, 1);
         chk("t1_done", done0, 0);
         @(negedge clk);
      end
      chk("t1_done_t17", done0, 1);
      chk("t1_busy_t17", busy0, 0);
      chk("t1_rows_t17", {29'd0, x3_0, x2_0, x1_0}, 32'd0);
      chk("t1_table",    table0, 32'hAC);
      chk("t1_match",    match0, 1);
`ifdef TT_FIRST_FAIL_EN
      chk("t1_ffval",    ffval0, 0);
`endif
      @(negedge clk);
      chk("t1_done_t18", done0, 0);
      chk("t1_hold_tbl", table0, 32'hAC);
      chk("t1_hold_mat", match0, 1);

      // Test 2: f stuck at 0
      fstuck = 1'b1;
      pulse0();
      chk("t2_table_clr", table0, 0);
      repeat (16) @(negedge clk);
      chk("t2_done",  done0, 1);
      chk("t2_table", table0, 0);
      chk("t2_match", match0, 0);
`ifdef TT_FIRST_FAIL_EN
      chk("t2_ffrow", ffrow0, 2);
      chk("t2_ffval", ffval0, 1);
`endif
      fstuck = 1'b0;
      @(negedge clk);

      // Test 3: zero settle, f = x1
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("t3_busy_t1", busy1, 1);
      chk("t3_row_t1",  {29'd0, x3_1, x2_1, x1_1}, 32'd0);
      repeat (7) @(negedge clk);
      chk("t3_busy_t8", busy1, 1);
      chk("t3_row_t8",  {29'd0, x3_1, x2_1, x1_1}, 32'd7);
      chk("t3_done_t8", done1, 0);
      @(negedge clk);
      chk("t3_done_t9", done1, 1);
      chk("t3_busy_t9", busy1, 0);
      chk("t3_table",   table1, 32'hAA);
      chk("t3_match",   match1, 0);
      @(negedge clk);

      // Test 4: reset during row 4
      pulse0();
      repeat (8) @(negedge clk);
      chk("t4_row4", {29'd0, x3_0, x2_0, x1_0}, 32'd4);
      #1 resetn = 1'b0;
      #1;
      chk("t4_rows", {29'd0, x3_0, x2_0, x1_0}, 32'd0);
      chk("t4_busy",  busy0, 0);
      chk("t4_table", table0, 0);
      chk("t4_match", match0, 0);
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done0 === 1'b1) done_cnt++;
      end
      resetn = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done0 === 1'b1) done_cnt++;
      end
      chk("t4_no_done", done_cnt, 0);
      pulse0();
      repeat (16) @(negedge clk);
      chk("t4_done",  done0, 1);
      chk("t4_table", table0, 32'hAC);
      chk("t4_match", match0, 1);
      @(negedge clk);

      // Test 5: extra start pulses during sweep and in FINISH
      pulse0();
      repeat (4) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (11) @(negedge clk);
      start0 = 1'b1;
      chk("t5_done_t17", done0, 1);
      chk("t5_table",    table0, 32'hAC);
      @(negedge clk);
      start0 = 1'b0;
      chk("t5_busy_t18", busy0, 0);
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (done0 === 1'b1 || busy0 === 1'b1) done_cnt++;
         @(negedge clk);
      end
      chk("t5_no_restart", done_cnt, 0);
      chk("t5_table_hold", table0, 32'hAC);
      chk("t5_match_hold", match0, 1);

      // Test 6: start held for 40 cycles
      done_at.delete();
      start0 = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done0 === 1'b1) begin
            done_at.push_back(i);
            chk("t6_match", match0, 1);
            chk("t6_table", table0, 32'hAC);
         end
      end
      start0 = 1'b0;
      chk("t6_done_count", done_at.size(), 2);
      if (done_at.size() >= 2) begin
         chk("t6_done1", done_at[0], 17);
         chk("t6_done2", done_at[1], 35);
      end
      done_cnt = 0;
      for (int i = 0; i < 40 && done_cnt == 0; i++) begin
         @(negedge clk);
         if (done0 === 1'b1) done_cnt++;
      end
      chk("t6_third_done", done_cnt, 1);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/truthtable_sweeper.md
Name: truthtable_sweeper

Overview:
Self-checking stimulus/capture stage for 3-input combinational truth-table circuits. On `start` it drives `x3:x1` through rows 0..7 into the circuit under test. It samples the circuit's `f` back after a programmable settle time and assembles the observed 8-row truth table. It then compares that table against an expected constant and reports pass/fail. It sits directly upstream (drives `x3`/`x2`/`x1`) and downstream (consumes `f`) of the truth-table circuit.

Parameters:
- `SETTLE_CYCLES`, default 1: extra cycles each row is held before `f` is sampled. Legal range 0..15.
- `EXPECTED`, default 8'hAC: expected table; bit i = expected `f` for row i = {x3,x2,x1}. 8'hAC encodes f = (~x3&x2)|(x3&x1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `x3`  out  1  row bit 2 to circuit under test.
- `x2`  out  1  row bit 1.
- `x1`  out  1  row bit 0.
- `f`  in  1  circuit-under-test output (combinational from `x3:x1`).
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `table_out`  out  8  observed table; bit i = sampled `f` for row i.
- `match`  out  1  `table_out == EXPECTED`, valid from `done` until next start.

Behaviour:
- Reset (`resetn` low, asynchronous, any state):
  - state = IDLE.
  - `x3`/`x2`/`x1` = 0, `busy` = 0, `done` = 0, `table_out` = 8'h00, `match` = 0.
  - Row counter = 0, settle counter = 0.
- All outputs are registered. `x3:x1` is the 3-bit row counter.
- States: IDLE, SWEEP, FINISH.
- IDLE:
  - `x3:x1` = 000.
  - `start` = 1 at an edge → next cycle: SWEEP, `busy` = 1, row = 0, settle = 0, `table_out` cleared to 0, `match` cleared to 0.
- SWEEP, each cycle:
  - If settle < `SETTLE_CYCLES`: settle++.
  - Else: `table_out[row]` <= `f`, settle <= 0.
    - If row == 7 → FINISH.
    - Else row++.
  - Each row is held `SETTLE_CYCLES`+1 cycles. `f` is sampled on the last of them.
  - With `SETTLE_CYCLES` = 0, each row takes 1 cycle and is sampled in the cycle it is driven.
- FINISH (exactly 1 cycle):
  - `done` = 1, `busy` = 0.
  - `match` = (`table_out` == `EXPECTED`), using the final `table_out` including row 7.
  - `x3:x1` returns to 000. Next state IDLE.
- Latency: `start` accepted at edge T → `busy` high T+1 .. T+8·(`SETTLE_CYCLES`+1) → `done` high in the following cycle.
  - Default `SETTLE_CYCLES` = 1: 16 `busy` cycles, `done` in cycle T+17.
- `start` while `busy` or in FINISH: ignored, no restart. `start` held high continuously: back-to-back sweeps, each beginning from IDLE (one IDLE cycle between).
- `table_out` and `match` hold their values after `done` until the next accepted `start`.
- Row counter and table indices wrap only by FINISH; row never increments past 7.
- `resetn` asserted mid-sweep: immediate return to the reset values above. No `done` pulse. Partial table discarded.
- `f` is X/unknown: no special handling; it is captured as-is.

Optional Feature:
- Macro: `TT_FIRST_FAIL_EN`.
- Defined:
  - Adds output ports `first_fail_row` (out, 3) and `first_fail_valid` (out, 1).
  - During SWEEP, the first sampled row whose `f` differs from `EXPECTED[row]` latches its index into `first_fail_row` and sets `first_fail_valid` = 1.
  - Later mismatches do not overwrite it.
  - Both are cleared on reset and on accepted `start`, and held after `done`.
  - `first_fail_valid` == ~`match` once `done` has pulsed.
- Undefined: ports and logic absent. All other behaviour is identical.

Test Plan:
1. Reset then `start` pulse, `f` driven by the correct function (~x3&x2)|(x3&x1), defaults → `x3:x1` steps 0..7 with each row held 2 cycles; `done` at T+17; `table_out` = 8'hAC; `match` = 1.
2. Same stimulus, but `f` stuck at 0 → `table_out` = 8'h00, `match` = 0. With `TT_FIRST_FAIL_EN`: `first_fail_row` = 2, `first_fail_valid` = 1.
3. `SETTLE_CYCLES` = 0, `f` = x1 → 8 `busy` cycles, `done` at T+9, `table_out` = 8'hAA, `match` = 0.
4. Assert `resetn` = 0 during row 4 of a sweep → all outputs 0 immediately, no `done`. A new `start` produces a full 8'hAC sweep.
5. Pulse `start` again at T+5 and at T+17 (the FINISH cycle) → both ignored; a single `done`; `table_out` unchanged by the extra pulses.
6. `start` held high for 40 cycles, correct `f` → two complete sweeps, `done` at T+17 and T+35, `match` = 1 both times.
